// File: rtl/char_buffer_ctrl.sv
// Character cell store for the VGA text renderer: arbitrates keyboard and host
// writes, runs a one-cell-per-cycle clear, and copies to the display on vsync.
module char_buffer_ctrl #(
    parameter int         DEPTH      = 40,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic               VGA_CLK_IN,
    input  logic               rst,
    input  logic               a_req,
    input  logic               a_op,
    input  logic [7:0]         a_char,
    output logic               a_ack,
    input  logic               b_req,
    input  logic [5:0]         b_addr,
    input  logic [7:0]         b_data,
    output logic               b_ack,
    output logic               b_err,
    input  logic               clr_req,
    output logic               clr_busy,
    input  logic               vsync_in,
    output logic [8*DEPTH-1:0] disp_flat,
    output logic [5:0]         cursor,
    output logic               commit_pulse
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);
    localparam logic [6:0] DEPTH_W  = 7'(DEPTH);

    logic [0:0] state;
    logic [5:0] clr_idx;
    logic [7:0] work [DEPTH];
    logic       dirty;
    logic       vsync_prev;
    logic       prio_b;

    logic       a_elig;
    logic       b_elig;
    logic       grant_a;
    logic       grant_b;
    logic       b_in_range;
    logic       rise;
    logic       commit;
    logic       clr_done;
    logic       wr_en;
    logic [5:0] wr_idx;
    logic [7:0] wr_data;
    logic [5:0] cursor_next;

    assign clr_busy   = (state == ST_CLEAR);
    assign clr_done   = clr_busy && (clr_idx == LAST_IDX);
    assign a_elig     = a_req & ~a_ack;
    assign b_elig     = b_req & ~b_ack;
    assign b_in_range = ({1'b0, b_addr} < DEPTH_W);
    assign rise       = vsync_in & ~vsync_prev;
    assign commit     = rise & dirty;

    // A pending clear request blocks both ports; ties go to whoever was not served last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == ST_IDLE && !clr_req) begin
            if (a_elig && (!b_elig || !prio_b)) begin
                grant_a = 1'b1;
            end else if (b_elig) begin
                grant_b = 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        wr_en       = 1'b0;
        wr_idx      = clr_idx;
        wr_data     = BLANK_CHAR;
        cursor_next = cursor;
        if (clr_busy) begin
            wr_en = 1'b1;
            if (clr_done) begin
                cursor_next = '0;
            end
        end else if (grant_a) begin
            wr_en = 1'b1;
            if (!a_op) begin
                wr_idx  = cursor;
                wr_data = a_char;
                if (cursor < LAST_IDX) begin
                    cursor_next = cursor + 6'd1;
                end
            end else begin
                wr_idx      = (cursor == 6'd0) ? 6'd0 : cursor - 6'd1;
                cursor_next = wr_idx;
            end
        end else if (grant_b) begin
            wr_en   = b_in_range;
            wr_idx  = b_addr;
            wr_data = b_data;
        end
    end

    always_ff @(posedge VGA_CLK_IN or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            clr_idx      <= '0;
            cursor       <= '0;
            dirty        <= 1'b0;
            vsync_prev   <= 1'b0;
            prio_b       <= 1'b0;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            b_err        <= 1'b0;
            commit_pulse <= 1'b0;
        end else begin
            vsync_prev   <= vsync_in;
            a_ack        <= grant_a;
            b_ack        <= grant_b;
            b_err        <= grant_b & ~b_in_range;
            commit_pulse <= commit;
            cursor       <= cursor_next;
            if (grant_a) begin
                prio_b <= 1'b1;
            end else if (grant_b) begin
                prio_b <= 1'b0;
            end
            // A write on a commit edge wins, so it shows up in the next frame.
            if (wr_en) begin
                dirty <= 1'b1;
            end else if (commit) begin
                dirty <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_idx <= '0;
                    end
                end
                ST_CLEAR: begin
                    clr_idx <= clr_idx + 6'd1;
                    if (clr_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the cells must come out of reset as BLANK_CHAR, so they are reset
    // registers rather than a RAM.
    always_ff @(posedge VGA_CLK_IN or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                work[i] <= BLANK_CHAR;
            end
            disp_flat <= {DEPTH{BLANK_CHAR}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && wr_idx == 6'(i)) begin
                    work[i] <= wr_data;
                end
                // NOTE: non-blocking, so the copy sees work as it stood before this edge.
                if (commit) begin
                    disp_flat[8*i +: 8] <= work[i];
                end
            end
        end
    end
endmodule
